// File: rtl/lane_rr_sched.sv
// Round-robin arbiter that grants one requester at a time access to a shared resource lane.
// Latency: a request seen in IDLE is granted the next cycle (START), then the FSM holds in WAIT until res_done or timeout.
// Backpressure: further grants stall while busy; at least one IDLE cycle separates consecutive grants.
module lane_rr_sched #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 255,
  localparam int SW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SW-1:0]      res_sel,
  output logic               res_start,
  input  logic               res_done,
  output logic               busy,
  output logic               timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t               r_state;
  logic [NUM_REQ-1:0]   r_gnt;
  logic [SW-1:0]        r_sel;
  logic                 r_start;
  logic                 r_terr;
  logic [15:0]          r_cnt;
  logic [SW-1:0]        r_ptr;

  logic [SW:0]          w_base;
  logic [2*NUM_REQ-1:0] w_dbl;
  logic [NUM_REQ-1:0]   w_rot;
  logic [SW:0]          w_off;
  logic [SW:0]          w_sum;
  logic [SW-1:0]        w_win;
  logic                 w_any;
  logic                 w_tmo;

  // Round-robin pick: rotate req so index ptr+1 lands at bit 0, take the lowest set bit, map back.
  always_comb begin
    w_base = {1'b0, r_ptr} + (SW+1)'(1);
    w_dbl  = {req, req} >> w_base;
    w_rot  = w_dbl[NUM_REQ-1:0];
    w_off  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_off = (SW+1)'(k);
      end
    end
    w_sum = w_base + w_off;
    if (w_sum >= (SW+1)'(NUM_REQ)) begin
      w_sum = w_sum - (SW+1)'(NUM_REQ);
    end
    w_win = w_sum[SW-1:0];
    w_any = |req;
    w_tmo = (r_cnt == 16'(TIMEOUT - 1));
  end

  // Arbitration FSM; every output is a register or a decode of r_state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_sel   <= '0;
      r_start <= 1'b0;
      r_terr  <= 1'b0;
      r_cnt   <= '0;
      r_ptr   <= SW'(NUM_REQ - 1);
    end else begin
      r_start <= 1'b0;
      r_terr  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win;
            r_sel   <= w_win;
            r_start <= 1'b1;
            r_state <= S_START;
          end
        end
        S_START: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // res_done has priority over a timeout landing in the same cycle
          if (res_done) begin
            r_gnt   <= '0;
            r_ptr   <= r_sel;
            r_state <= S_IDLE;
          end else if (w_tmo) begin
            r_gnt   <= '0;
            r_ptr   <= r_sel;
            r_terr  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: begin
          r_gnt   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt         = r_gnt;
  assign res_sel     = r_sel;
  assign res_start   = r_start;
  assign timeout_err = r_terr;
  assign busy        = (r_state != S_IDLE);

endmodule
